uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit core between N_REQ byte-stream requesters (e.g. test stimulus, status reporter, loopback echo).
- Grants are packet-level, round-robin; the grant holds until the requester's last byte is accepted.
- Enforces a configurable idle gap between packets and a burst-length watchdog.
- Sits between requester FIFOs and the UART TX serializer that drives the bus tx line.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- GAP_CYCLES, 16, idle clk cycles between packets; 0 means no gap.
- MAX_BURST, 256, maximum bytes per grant before forced release; legal range 1..65535.
- ID_W, $clog2(N_REQ), width of grant_id.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  N_REQ  per-requester marker: current byte ends the packet.
- req_ready  output  N_REQ  per-requester byte accepted.
- tx_valid  output  1  byte valid to the UART TX core.
- tx_data  output  8  byte to the UART TX core.
- tx_ready  input  1  UART TX core can accept a byte.
- grant_id  output  ID_W  index of the current or most recent grantee.
- busy  output  1  high in the XFER and GAP states.
- burst_abort  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, grant_id = 0, rr_ptr = N_REQ-1, so requester 0 has first priority.
  - byte_cnt = 0, gap_cnt = 0.
  - tx_valid, req_ready, busy and burst_abort are all 0.
- Reset asserted mid-packet: return to IDLE immediately. tx_valid drops asynchronously. Any partial packet is abandoned, with no flush.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If any req_valid is high, choose the first set bit searching from rr_ptr+1 upward with wrap-around.
  - Register grant_id = winner and rr_ptr = winner. Clear byte_cnt. Go to XFER.
  - Arbitration latency: req_valid at edge n, so tx_valid can first be high in cycle n+1.
  - If no request, stay in IDLE; grant_id holds.
- XFER (combinational passthrough, g = grant_id):
  - tx_valid = req_valid[g], tx_data = req_data[g].
  - req_ready[g] = tx_ready. All other req_ready bits are 0.
  - A handshake occurs when tx_valid and tx_ready are both high. On each handshake, byte_cnt increments.
  - Handshake with req_last[g] = 1: leave XFER.
  - Handshake with byte_cnt == MAX_BURST-1 and req_last = 0: leave XFER and pulse burst_abort for one cycle. The requester's remaining bytes re-arbitrate as a new packet.
  - Leaving XFER: go to GAP with gap_cnt = GAP_CYCLES-1 if GAP_CYCLES > 0; otherwise go to IDLE.
  - Requester deasserting req_valid mid-packet: the grant holds, with no timeout; tx_valid follows it low.
- GAP:
  - tx_valid = 0 and all req_ready = 0.
  - gap_cnt decrements each cycle. At 0, go to IDLE.
  - The total gap is exactly GAP_CYCLES cycles, with no handshake from the last handshake edge to IDLE entry.
- Outputs during IDLE and GAP: tx_data = 0.
- Round-robin fairness: with all requesters continuously active, grants rotate 0,1,...,N_REQ-1,0,...
- Simultaneous events: new requests arriving during XFER or GAP are only sampled in IDLE. There is no preemption.
- Width rules: byte_cnt is 16 bits. gap_cnt is $clog2(GAP_CYCLES+1) bits, minimum 1.

Test Plan:
- Reset then req_valid = 4'b0100, 3-byte packet 0x11,0x22,0x33 (last on 0x33), tx_ready = 1 -> grant_id = 2 one cycle after request. tx_data sequence 11,22,33 on three consecutive cycles. busy = 1 through GAP. tx_valid = 0 for 16 cycles after the last byte.
- All four requesters hold 1-byte packets continuously, GAP_CYCLES = 16 -> grant order 0,1,2,3,0. Each handshake is separated by 1 IDLE cycle plus 16 GAP cycles.
- tx_ready toggled 1,0,0,1 during a 2-byte packet from requester 1 -> req_ready[1] mirrors tx_ready. Exactly 2 handshakes occur. req_ready of other requesters stays 0.
- MAX_BURST = 4, requester 3 sends 6 bytes with last on byte 6, requester 0 idle -> burst_abort pulses on the 4th handshake. After the gap, requester 3 is re-granted and sends bytes 5..6.
- MAX_BURST = 4, requesters 0 and 3 both active, requester 3 granted first (rr_ptr = 2) with 6 bytes -> after the abort and gap, requester 0 is granted before requester 3's remainder.
- rst pulsed high during the 2nd byte of a 3-byte packet -> tx_valid = 0 and busy = 0 immediately. grant_id = 0. The next arbitration starts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter that shares one UART TX
// core between N_REQ byte-stream requesters. It enforces an idle gap between
// packets and a burst-length watchdog.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 burst_abort
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic              arb_found;
  logic [ID_W-1:0]   arb_idx;
  int unsigned       arb_dist;
  int unsigned       arb_best;

  logic              sel_valid;
  logic              sel_last;
  logic [7:0]        sel_data;
  logic [N_REQ-1:0]  sel_onehot;
  logic              handshake;

  assign grant_id = grant_q;

  // Round-robin pick: distance 0 is the requester just after rr_ptr, the lowest distance wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_best  = N_REQ;
    arb_dist  = 0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      arb_dist = (j + N_REQ - 1 - 32'(rr_ptr_q)) % N_REQ;
      if (req_valid[j] && (arb_dist < arb_best)) begin
        arb_best  = arb_dist;
        arb_idx   = ID_W'(j);
        arb_found = 1'b1;
      end
    end
  end

  // Select the current grantee's byte stream.
  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (grant_q == ID_W'(j)) begin
        sel_valid     = req_valid[j];
        sel_last      = req_last[j];
        sel_data      = req_data[8*j +: 8];
        sel_onehot[j] = 1'b1;
      end
    end
  end

  // Next-state logic and outputs of the IDLE/XFER/GAP controller.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_valid    = 1'b0;
    tx_data     = '0;
    req_ready   = '0;
    busy        = 1'b0;
    burst_abort = 1'b0;
    handshake   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d    = arb_idx;
          rr_ptr_d   = arb_idx;
          byte_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        busy      = 1'b1;
        tx_valid  = sel_valid;
        tx_data   = sel_data;
        req_ready = {N_REQ{tx_ready}} & sel_onehot;
        handshake = sel_valid & tx_ready;
        if (handshake) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (sel_last || (byte_cnt_q == BURST_LAST)) begin
            burst_abort = ~sel_last;
            if (GAP_CYCLES > 0) begin
              state_d   = GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d   = IDLE;
            end
          end
        end
      end
      GAP: begin
        busy = 1'b1;
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester sources are driven from
// byte tables, and a scoreboard holds the expected grant/byte/abort order.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        burst_abort;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [8:0]  mem [4][8];
  int unsigned len [4];
  int unsigned rd  [4];

  typedef struct packed {
    logic       ab;
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int iv4 [6] = '{1, 1, 1, 1, 18, 1};
  int iv5 [8] = '{1, 1, 1, 1, 18, 1, 18, 1};
  logic [7:0] t1_bytes [3] = '{8'h11, 8'h22, 8'h33};
  logic       t3_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  uart_tx_arbiter #(
    .N_REQ      (4),
    .GAP_CYCLES (16),
    .MAX_BURST  (4),
    .ID_W       (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .burst_abort (burst_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (rd[i] < len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = mem[i][rd[i]][7:0];
        req_last[i]        = mem[i][rd[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      rd[i]  = 0;
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic last);
    mem[r][len[r]] = {last, d};
    len[r]++;
  endtask

  task automatic expect_b(input logic ab, input logic [1:0] id, input logic [7:0] d);
    sb.push_back({ab, id, d});
  endtask

  // One clock: bytes accepted at this edge are popped from their sources.
  task automatic tick();
    logic [3:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) rd[i]++;
    drive();
    #1;
  endtask

  task automatic wait_hs(output int n);
    tick();
    n = 1;
    while (!(tx_valid && tx_ready) && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    drive();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Scoreboard monitor: every handshake must match the next expected byte.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid && tx_ready) begin
        chk("sb_nonempty_at_hs", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("hs_data",      32'(tx_data),     32'(mon_e.d));
          chk("hs_grant",     32'(grant_id),    32'(mon_e.id));
          chk("hs_abort",     32'(burst_abort), 32'(mon_e.ab));
          chk("hs_req_ready", 32'(req_ready),   32'd1 << mon_e.id);
        end
      end else begin
        chk("abort_no_hs", 32'(burst_abort), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs;
    rst       = 1'b1;
    tx_ready  = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_src();
    #2;
    chk("rst_tx_valid",  32'(tx_valid),    32'd0);
    chk("rst_req_ready", 32'(req_ready),   32'd0);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_abort",     32'(burst_abort), 32'd0);
    chk("rst_grant",     32'(grant_id),    32'd0);
    chk("rst_tx_data",   32'(tx_data),     32'd0);
    do_reset();
    mon_en = 1'b1;

    // 3-byte packet from requester 2, then a 16-cycle gap.
    load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h33, 1'b1);
    expect_b(1'b0, 2'd2, 8'h11); expect_b(1'b0, 2'd2, 8'h22); expect_b(1'b0, 2'd2, 8'h33);
    drive();
    #1;
    chk("t1_idle_tx_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("t1_grant", 32'(grant_id), 32'd2);
    for (int k = 0; k < 3; k++) begin
      chk("t1_tx_valid", 32'(tx_valid), 32'd1);
      chk("t1_tx_data",  32'(tx_data),  32'(t1_bytes[k]));
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      chk("t1_gap_busy",     32'(busy),     32'd1);
      chk("t1_gap_tx_valid", 32'(tx_valid), 32'd0);
      chk("t1_gap_tx_data",  32'(tx_data),  32'd0);
      tick();
    end
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Round robin with all requesters active.
    do_reset();
    load(0, 8'hA0, 1'b1); load(1, 8'hA1, 1'b1); load(2, 8'hA2, 1'b1);
    load(3, 8'hA3, 1'b1); load(0, 8'hA4, 1'b1);
    expect_b(1'b0, 2'd0, 8'hA0); expect_b(1'b0, 2'd1, 8'hA1); expect_b(1'b0, 2'd2, 8'hA2);
    expect_b(1'b0, 2'd3, 8'hA3); expect_b(1'b0, 2'd0, 8'hA4);
    drive();
    wait_hs(n);
    chk("rr_first_latency", 32'(n), 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_hs(n);
      chk("rr_spacing", 32'(n), 32'd18);
    end
    wait_idle();

    // Backpressure on requester 1.
    load(1, 8'hB1, 1'b0); load(1, 8'hB2, 1'b1);
    expect_b(1'b0, 2'd1, 8'hB1); expect_b(1'b0, 2'd1, 8'hB2);
    drive();
    tick();
    hs = 0;
    for (int k = 0; k < 4; k++) begin
      tx_ready = t3_pat[k];
      #1;
      chk("t3_req_ready", 32'(req_ready), {30'd0, t3_pat[k], 1'b0});
      if (tx_valid && tx_ready) hs++;
      tick();
    end
    tx_ready = 1'b1;
    #1;
    chk("t3_handshakes", 32'(hs), 32'd2);
    chk("t3_in_gap",     32'(busy && !tx_valid), 32'd1);
    wait_idle();

    // Burst watchdog: requester 3 alone, 6 bytes.
    for (int k = 1; k <= 6; k++) begin
      load(3, 8'hC0 + 8'(k), logic'(k == 6));
      expect_b(logic'(k == 4), 2'd3, 8'hC0 + 8'(k));
    end
    drive();
    for (int k = 0; k < 6; k++) begin
      wait_hs(n);
      chk("t4_interval", 32'(n), 32'(iv4[k]));
    end
    wait_idle();

    // Set rr_ptr to 2 with a single byte from requester 2.
    load(2, 8'hD0, 1'b1);
    expect_b(1'b0, 2'd2, 8'hD0);
    drive();
    wait_hs(n);
    chk("t5_pre_latency", 32'(n), 32'd1);
    wait_idle();

    // Requesters 3 (6 bytes) and 0 (2 bytes) compete; 0 goes before 3's remainder.
    for (int k = 1; k <= 6; k++) load(3, 8'hE0 + 8'(k), logic'(k == 6));
    load(0, 8'hF1, 1'b0); load(0, 8'hF2, 1'b1);
    for (int k = 1; k <= 4; k++) expect_b(logic'(k == 4), 2'd3, 8'hE0 + 8'(k));
    expect_b(1'b0, 2'd0, 8'hF1); expect_b(1'b0, 2'd0, 8'hF2);
    expect_b(1'b0, 2'd3, 8'hE5); expect_b(1'b0, 2'd3, 8'hE6);
    drive();
    for (int k = 0; k < 8; k++) begin
      wait_hs(n);
      chk("t5_interval", 32'(n), 32'(iv5[k]));
    end
    wait_idle();

    // Asynchronous reset during the second byte of a packet.
    load(2, 8'h61, 1'b0); load(2, 8'h62, 1'b0); load(2, 8'h63, 1'b1);
    expect_b(1'b0, 2'd2, 8'h61);
    drive();
    wait_hs(n);
    chk("t6_first_latency", 32'(n), 32'd1);
    tick();
    chk("t6_second_byte", 32'(tx_data), 32'h62);
    rst = 1'b1;
    #1;
    chk("t6_rst_tx_valid",  32'(tx_valid),  32'd0);
    chk("t6_rst_busy",      32'(busy),      32'd0);
    chk("t6_rst_grant",     32'(grant_id),  32'd0);
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    clear_src();
    drive();
    tick();
    rst = 1'b0;
    #1;
    load(3, 8'h73, 1'b1); load(0, 8'h70, 1'b1);
    expect_b(1'b0, 2'd0, 8'h70); expect_b(1'b0, 2'd3, 8'h73);
    drive();
    wait_hs(n);
    chk("t6_post_first", 32'(n), 32'd1);
    chk("t6_post_grant", 32'(grant_id), 32'd0);
    wait_hs(n);
    chk("t6_post_second", 32'(n), 32'd18);
    wait_idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
